mips_multicycle_ctrl: RTL and testbench

//  Moore/Mealy FSM that sequences a multicycle MIPS datapath built from the single-cycle core's ALU, reg file and memory.

---
 rtl/mips_multicycle_ctrl_if.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller/datapath signal bundle for the multicycle MIPS sequencer
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic       illegal;

  // controller side: decodes instruction fields and drives datapath strobes
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, state, illegal
  );

  // datapath side: supplies IR fields, ALU flag and memory handshake
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, state, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM; MC_PERF_CNT_EN adds cycle/retire counters
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_multicycle_ctrl_if.master  bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]             cycle_count,
  output logic [31:0]             instr_retired
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ERROR   = 4'd15
  } state_t;

  // Moore part of the strobes; ir_write and the FETCH/BRANCH pc_en terms are added combinationally
  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       illegal;
  } ctrl_t;

  localparam bit                   TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_t               cur;
  state_t               nxt;
  ctrl_t                q;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 is_wait;
  logic                 timeout_hit;
  logic                 run;

  function automatic logic [2:0] alu_op(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    c.alu_control = 3'b010;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.i_or_d = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:   begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE: begin c.alu_src_a = 1'b1; c.alu_control = alu_op(fn); end
      S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_control = alu_op(fn); end
      S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01; end
      S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:  c.reg_write = 1'b1;
      S_JUMP:    begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
      S_ERROR:   c.illegal = 1'b1;
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  assign is_wait     = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  // the limit cycle is the one where the counter already equals TIMEOUT_CYCLES; a ready there still advances
  assign timeout_hit = TO_EN && !bus.mem_ready && (wait_cnt == TO_LIM);

  // next-state selection from current state, opcode/funct and memory handshake
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH: begin
        if (bus.mem_ready)    nxt = S_DECODE;
        else if (timeout_hit) nxt = S_ERROR;
      end
      S_DECODE: begin
        case (bus.opcode)
          6'h23, 6'h2B: nxt = S_MEMADR;
          6'h00:        nxt = S_EXECUTE;
          6'h04:        nxt = S_BRANCH;
          6'h08:        nxt = S_ADDIEX;
          6'h02:        nxt = S_JUMP;
          default:      nxt = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == 6'h23)      nxt = S_MEMRD;
        else if (bus.opcode == 6'h2B) nxt = S_MEMWR;
        else                          nxt = S_ERROR;
      end
      S_MEMRD: begin
        if (bus.mem_ready)    nxt = S_MEMWB;
        else if (timeout_hit) nxt = S_ERROR;
      end
      S_MEMWR: begin
        if (bus.mem_ready)    nxt = S_FETCH;
        else if (timeout_hit) nxt = S_ERROR;
      end
      S_EXECUTE: nxt = funct_ok(bus.funct) ? S_ALUWB : S_ERROR;
      S_ADDIEX:  nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: nxt = S_FETCH;
      S_ERROR:   nxt = S_ERROR;
      default:   nxt = S_ERROR;
    endcase
  end

  // state, wait counter and strobes registered from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      q        <= decode(S_FETCH, 6'd0);
    end else begin
      cur <= nxt;
      q   <= decode(nxt, bus.funct);
      if ((nxt == cur) && is_wait && !bus.mem_ready) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      else                                          wait_cnt <= '0;
    end
  end

  // reset forces the documented idle values without waiting for a clock
  assign run             = ~reset;
  assign bus.pc_en       = run & (q.pc_en | ((cur == S_FETCH) & bus.mem_ready) | ((cur == S_BRANCH) & bus.zero));
  assign bus.ir_write    = run & (cur == S_FETCH) & bus.mem_ready;
  assign bus.pc_src      = run ? q.pc_src : 2'b00;
  assign bus.i_or_d      = run & q.i_or_d;
  assign bus.mem_read    = run & q.mem_read;
  assign bus.mem_write   = run & q.mem_write;
  assign bus.reg_dst     = run & q.reg_dst;
  assign bus.mem_to_reg  = run & q.mem_to_reg;
  assign bus.reg_write   = run & q.reg_write;
  assign bus.alu_src_a   = run & q.alu_src_a;
  assign bus.alu_src_b   = run ? q.alu_src_b : 2'b00;
  assign bus.alu_control = run ? q.alu_control : 3'b010;
  assign bus.illegal     = run & q.illegal;
  assign bus.state       = cur;

`ifdef MC_PERF_CNT_EN
  // free-running cycle counter and count of instructions returning to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= '0;
      instr_retired <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if ((nxt == S_FETCH) && (cur != S_FETCH)) instr_retired <= instr_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized trace-model bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  localparam int          TO      = 4;
  localparam logic [16:0] RST_OUT = 17'h00004;

  logic       clk;
  logic       reset;
  logic [5:0] cur_fn;
  int         n_checks;
  int         n_fail;
  int         trace[$];

  mips_multicycle_ctrl_if bus();

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_retired;
  int unsigned cyc_model;
  int unsigned ret_model;
`endif

  mips_multicycle_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_count(cycle_count),
    .instr_retired(instr_retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MC_PERF_CNT_EN
  always @(posedge clk) if (!reset) cyc_model++;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  // spec output table: strobes seen in a given state for given mem_ready/zero
  function automatic logic [16:0] exp_out(input int st, input int rdy, input int z, input logic [5:0] fn);
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_a, ill;
    logic [1:0] pc_src, alu_b;
    logic [2:0] alu;
    pc_en = 0; i_or_d = 0; mem_read = 0; mem_write = 0; ir_write = 0; reg_dst = 0;
    mem_to_reg = 0; reg_write = 0; alu_a = 0; ill = 0; pc_src = 0; alu_b = 0; alu = 3'b010;
    case (st)
      0:  begin mem_read = 1; alu_b = 2'b01; ir_write = (rdy != 0); pc_en = (rdy != 0); end
      1:  alu_b = 2'b11;
      2:  begin alu_a = 1; alu_b = 2'b10; end
      3:  begin i_or_d = 1; mem_read = 1; end
      4:  begin mem_to_reg = 1; reg_write = 1; end
      5:  begin i_or_d = 1; mem_write = 1; end
      6:  begin alu_a = 1; alu = alu_of(fn); end
      7:  begin reg_dst = 1; reg_write = 1; alu = alu_of(fn); end
      8:  begin alu_a = 1; alu = 3'b110; pc_src = 2'b01; pc_en = (z != 0); end
      9:  begin alu_a = 1; alu_b = 2'b10; end
      10: reg_write = 1;
      11: begin pc_src = 2'b10; pc_en = 1; end
      15: ill = 1;
      default: ;
    endcase
    return {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_a, alu_b, alu, ill};
  endfunction

  function automatic logic [16:0] got_out();
    return {bus.pc_en, bus.pc_src, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_control, bus.illegal};
  endfunction

  function automatic void push(input int st, input int rdy, input int z);
    trace.push_back(st * 4 + ((z != 0) ? 2 : 0) + ((rdy != 0) ? 1 : 0));
  endfunction

  // d not-ready cycles then ready; more than TO stalls ends in a trap
  function automatic bit push_wait(input int st, input int d);
    int zeros;
    zeros = (d > TO) ? TO + 1 : d;
    for (int i = 0; i < zeros; i++) push(st, 0, int'($urandom % 2));
    if (d > TO) return 1'b1;
    push(st, 1, int'($urandom % 2));
    return 1'b0;
  endfunction

  // expected state path of one instruction; returns 1 when it ends in ERROR
  function automatic bit build(input logic [5:0] op, input logic [5:0] fn, input int d0, input int d1, input int bz);
    if (push_wait(0, d0)) return 1'b1;
    push(1, int'($urandom % 2), int'($urandom % 2));
    case (op)
      6'h23: begin
        push(2, int'($urandom % 2), int'($urandom % 2));
        if (push_wait(3, d1)) return 1'b1;
        push(4, int'($urandom % 2), int'($urandom % 2));
      end
      6'h2B: begin
        push(2, int'($urandom % 2), int'($urandom % 2));
        if (push_wait(5, d1)) return 1'b1;
      end
      6'h00: begin
        push(6, int'($urandom % 2), int'($urandom % 2));
        if (!legal_fn(fn)) return 1'b1;
        push(7, int'($urandom % 2), int'($urandom % 2));
      end
      6'h04: push(8, int'($urandom % 2), bz);
      6'h08: begin
        push(9, int'($urandom % 2), int'($urandom % 2));
        push(10, int'($urandom % 2), int'($urandom % 2));
      end
      6'h02: push(11, int'($urandom % 2), int'($urandom % 2));
      default: return 1'b1;
    endcase
    return 1'b0;
  endfunction

  task automatic run_trace();
`ifdef MC_PERF_CNT_EN
    bit first;
    first = 1'b1;
`endif
    while (trace.size() > 0) begin
      int e;
      int st;
      int rdy;
      int z;
      e   = trace.pop_front();
      st  = e / 4;
      z   = (e / 2) % 2;
      rdy = e % 2;
      @(negedge clk);
      reset         = 1'b0;
      bus.mem_ready = (rdy != 0);
      bus.zero      = (z != 0);
      #1;
      check("state", 32'(bus.state), 32'(st));
      check($sformatf("outputs_s%0d", st), 32'(got_out()), 32'(exp_out(st, rdy, z, cur_fn)));
`ifdef MC_PERF_CNT_EN
      if (first) begin
        check("cycle_count", cycle_count, cyc_model);
        check("instr_retired", instr_retired, ret_model);
      end
      first = 1'b0;
`endif
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
`ifdef MC_PERF_CNT_EN
    cyc_model = 0;
    ret_model = 0;
`endif
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_outputs", 32'(got_out()), 32'(RST_OUT));
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_state", 32'(bus.state), 32'd0);
    check("rst_hold_outputs", 32'(got_out()), 32'(RST_OUT));
`ifdef MC_PERF_CNT_EN
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_instr_retired", instr_retired, 32'd0);
`endif
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int d0, input int d1, input int bz);
    bit err;
    bus.opcode = op;
    bus.funct  = fn;
    cur_fn     = fn;
    err = build(op, fn, d0, d1, bz);
    if (err) for (int i = 0; i < 3; i++) push(15, int'($urandom % 2), int'($urandom % 2));
    run_trace();
    if (err) begin
      @(negedge clk);
      reset_pulse();
    end
`ifdef MC_PERF_CNT_EN
    else ret_model++;
`endif
  endtask

  function automatic logic [5:0] pick_op(input int i);
    case (i)
      0:       return 6'h23;
      1:       return 6'h2B;
      2:       return 6'h00;
      3:       return 6'h04;
      4:       return 6'h08;
      default: return 6'h02;
    endcase
  endfunction

  function automatic logic [5:0] pick_fn(input int i);
    case (i)
      0:       return 6'h20;
      1:       return 6'h22;
      2:       return 6'h24;
      3:       return 6'h25;
      default: return 6'h2A;
    endcase
  endfunction

  function automatic int rnd_d();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(TO, TO + 2));
    return int'($urandom_range(0, 2));
  endfunction

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    cur_fn        = 6'd0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset_pulse();

    do_instr(6'h08, 6'h11, 0, 0, 0);
    do_instr(6'h00, 6'h20, 0, 0, 0);
    do_instr(6'h00, 6'h22, 0, 0, 0);
    do_instr(6'h00, 6'h3F, 0, 0, 0);
    do_instr(6'h23, 6'h00, 0, 3, 0);
    do_instr(6'h2B, 6'h00, 1, 2, 0);
    do_instr(6'h04, 6'h00, 0, 0, 1);
    do_instr(6'h04, 6'h00, 0, 0, 0);
    do_instr(6'h02, 6'h00, 0, 0, 0);
    do_instr(6'h3C, 6'h00, 0, 0, 0);
    do_instr(6'h08, 6'h00, TO, 0, 0);
    do_instr(6'h08, 6'h00, TO + 1, 0, 0);
    do_instr(6'h23, 6'h00, 0, TO + 1, 0);
    do_instr(6'h2B, 6'h00, 0, TO, 0);

    bus.opcode = 6'h2B;
    bus.funct  = 6'h00;
    cur_fn     = 6'h00;
    push(0, 1, 0);
    push(1, 0, 0);
    push(2, 0, 0);
    push(5, 0, 0);
    run_trace();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("memwr_pre_state", 32'(bus.state), 32'd5);
    check("memwr_pre_mem_write", 32'(bus.mem_write), 32'd1);
    reset_pulse();
    do_instr(6'h02, 6'h00, 0, 0, 0);

    for (int k = 0; k < 200; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pick_op(int'($urandom_range(0, 5)));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pick_fn(int'($urandom_range(0, 4)));
      do_instr(op, fn, rnd_d(), rnd_d(), int'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
